regfile_sb: RTL and testbench

Parametrised two-write, two-read register file with a load scoreboard. It serves as the next-generation register file of the MIPS datapath. It sits between decode (reads rs/rt, issues loads) and the two writeback sources: ALU writeback (port A) and memory load return (port B). Register 0 is hardwired to zero. Per-register busy bits flag destinations of outstanding loads so that decode can stall on RAW hazards.

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_sb_if.sv | 32 +++
 rtl/regfile_scoreboard.sv | 64 ++++++
 rtl/regfile_sb.sv | 64 ++++++
 tb/tb_regfile_sb.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the two-write, two-read register file with load scoreboard.
package regfile_pkg;
    localparam int WIDTH_DEF  = 32;
    localparam int DEPTH_DEF  = 32;
    localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);
    localparam int ZERO_REG   = 0;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_sb_if.sv
// Decode / writeback bus of the register file; master is the pipeline, slave is regfile_sb.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [WIDTH-1:0]  data1;
    logic [WIDTH-1:0]  data2;
    logic              regWrite;
    logic [ADDR_W-1:0] rd;
    logic [WIDTH-1:0]  writeData;
    logic              ldWrite;
    logic [ADDR_W-1:0] ldRd;
    logic [WIDTH-1:0]  ldData;
    logic              issueValid;
    logic [ADDR_W-1:0] issueRd;
    logic              stall;
    logic [ADDR_W:0]   pendingCount;

    modport master (
        output rs, rt, regWrite, rd, writeData, ldWrite, ldRd, ldData, issueValid, issueRd,
        input  data1, data2, stall, pendingCount
    );

    modport slave (
        input  rs, rt, regWrite, rd, writeData, ldWrite, ldRd, ldData, issueValid, issueRd,
        output data1, data2, stall, pendingCount
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Busy bits for outstanding loads, their pending count and the RAW stall.
// REGFILE_BYPASS_EN: a busy bit cleared by this cycle's load return no longer stalls.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              ld_write,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              stall,
    output logic [ADDR_W:0]   pending_count
);
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic             set_en;
    logic             clr_en;
    logic             same_reg;
    logic             inc;
    logic             dec;

    assign set_en   = issue_valid && (issue_rd != ADDR_W'(ZERO_REG));
    assign clr_en   = ld_write && (ld_rd != ADDR_W'(ZERO_REG));
    assign same_reg = set_en && clr_en && (issue_rd == ld_rd);
    assign inc      = set_en && !busy[issue_rd];
    assign dec      = clr_en && busy[ld_rd] && !same_reg;

    // Clear first, then set: a newly issued load supersedes the returning one.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[ld_rd] = 1'b0;
        if (set_en) busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy          <= '0;
            pending_count <= '0;
        end else begin
            busy          <= busy_nxt;
            pending_count <= pending_count + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [DEPTH-1:0] busy_eff;

    always_comb begin
        busy_eff = busy;
        if (clr_en && !same_reg) busy_eff[ld_rd] = 1'b0;
    end

    assign stall = busy_eff[rs] | busy_eff[rt];
`else
    assign stall = busy[rs] | busy[rt];
`endif
endmodule

// File: rtl/regfile_sb.sv
// Register file with ALU (port A) and load-return (port B) writes; r0 reads zero.
// REGFILE_BYPASS_EN: reads forward this cycle's write data, port A over port B.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  bus
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Port A is checked first so it wins a same-address collision with port B.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            mem[0] <= '0;
            for (int i = 1; i < DEPTH; i++) begin
                if (bus.regWrite && bus.rd == ADDR_W'(i))
                    mem[i] <= bus.writeData;
                else if (bus.ldWrite && bus.ldRd == ADDR_W'(i))
                    mem[i] <= bus.ldData;
            end
        end
    end

    function automatic logic [WIDTH-1:0] rd_port(input logic [ADDR_W-1:0] a);
        logic [WIDTH-1:0] v;
        if (a == ADDR_W'(ZERO_REG))
            v = '0;
`ifdef REGFILE_BYPASS_EN
        else if (bus.regWrite && bus.rd == a)
            v = bus.writeData;
        else if (bus.ldWrite && bus.ldRd == a)
            v = bus.ldData;
`endif
        else
            v = mem[a];
        return v;
    endfunction

    assign bus.data1 = rd_port(bus.rs);
    assign bus.data2 = rd_port(bus.rt);

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (bus.issueValid),
        .issue_rd      (bus.issueRd),
        .ld_write      (bus.ldWrite),
        .ld_rd         (bus.ldRd),
        .rs            (bus.rs),
        .rt            (bus.rt),
        .stall         (bus.stall),
        .pending_count (bus.pendingCount)
    );
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: writes, port priority, r0, scoreboard set/clear and reset.
module tb_regfile_sb;
    import regfile_pkg::*;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    regfile_sb_if #(.WIDTH(WIDTH_DEF), .ADDR_W(ADDR_W_DEF)) bus ();

    regfile_sb #(.WIDTH(WIDTH_DEF), .DEPTH(DEPTH_DEF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.regWrite   = 1'b0;
        bus.ldWrite    = 1'b0;
        bus.issueValid = 1'b0;
    endtask

    task automatic issue(input reg_addr_t r);
        bus.issueValid = 1'b1;
        bus.issueRd    = r;
        tick();
        idle();
    endtask

    task automatic ld_ret(input reg_addr_t r, input logic [31:0] d);
        bus.ldWrite = 1'b1;
        bus.ldRd    = r;
        bus.ldData  = d;
        tick();
        idle();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus.rs = '0; bus.rt = '0; bus.rd = '0; bus.ldRd = '0; bus.issueRd = '0;
        bus.writeData = '0; bus.ldData = '0;
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        for (int i = 0; i < DEPTH_DEF; i++) begin
            bus.rs = reg_addr_t'(i);
            bus.rt = reg_addr_t'(i);
            #1;
            chk($sformatf("rst_d1_%0d", i), bus.data1, 32'h0);
            chk($sformatf("rst_d2_%0d", i), bus.data2, 32'h0);
        end
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_pend", 32'(bus.pendingCount), 32'h0);

        // Port A write; same-cycle read depends on bypass.
        bus.regWrite = 1'b1; bus.rd = 5'd5; bus.writeData = 32'hDEADBEEF; bus.rs = 5'd5;
        #1;
        chk("wr5_same_cycle", bus.data1, BYP ? 32'hDEADBEEF : 32'h0);
        tick();
        idle();
        #1;
        chk("wr5_next", bus.data1, 32'hDEADBEEF);

        // Port A beats port B on the same address.
        bus.regWrite = 1'b1; bus.rd = 5'd7; bus.writeData = 32'h11;
        bus.ldWrite  = 1'b1; bus.ldRd = 5'd7; bus.ldData = 32'h22;
        bus.rt = 5'd7;
        #1;
        chk("ab_same_cycle", bus.data2, BYP ? 32'h11 : 32'h0);
        tick();
        idle();
        #1;
        chk("ab_prio", bus.data2, 32'h11);
        chk("ab_pend", 32'(bus.pendingCount), 32'h0);

        // r0 ignores writes.
        bus.regWrite = 1'b1; bus.rd = 5'd0; bus.writeData = 32'hFFFF;
        tick();
        idle();
        bus.rs = 5'd0;
        #1;
        chk("r0_zero", bus.data1, 32'h0);

        // Load return to a non-busy register writes data only.
        ld_ret(5'd8, 32'h33);
        bus.rs = 5'd8;
        #1;
        chk("ld_nonbusy_data", bus.data1, 32'h33);
        chk("ld_nonbusy_pend", 32'(bus.pendingCount), 32'h0);
        chk("ld_nonbusy_stall", 32'(bus.stall), 32'h0);

        // Issue r9, then return it.
        issue(5'd9);
        bus.rs = 5'd0; bus.rt = 5'd9;
        #1;
        chk("iss9_stall", 32'(bus.stall), 32'h1);
        chk("iss9_pend", 32'(bus.pendingCount), 32'h1);
        bus.ldWrite = 1'b1; bus.ldRd = 5'd9; bus.ldData = 32'h55;
        #1;
        chk("ret9_same_stall", 32'(bus.stall), BYP ? 32'h0 : 32'h1);
        chk("ret9_same_data", bus.data2, BYP ? 32'h55 : 32'h0);
        tick();
        idle();
        #1;
        chk("ret9_stall", 32'(bus.stall), 32'h0);
        chk("ret9_pend", 32'(bus.pendingCount), 32'h0);
        chk("ret9_data", bus.data2, 32'h55);

        // Same-cycle set and clear of busy r3: set wins.
        issue(5'd3);
        bus.rs = 5'd3; bus.rt = 5'd0;
        #1;
        chk("iss3_pend", 32'(bus.pendingCount), 32'h1);
        bus.issueValid = 1'b1; bus.issueRd = 5'd3;
        bus.ldWrite = 1'b1; bus.ldRd = 5'd3; bus.ldData = 32'h77;
        #1;
        chk("setclr_same_stall", 32'(bus.stall), 32'h1);
        tick();
        idle();
        #1;
        chk("setclr_stall", 32'(bus.stall), 32'h1);
        chk("setclr_pend", 32'(bus.pendingCount), 32'h1);
        chk("setclr_data", bus.data1, 32'h77);
        ld_ret(5'd3, 32'h78);
        chk("clr3_pend", 32'(bus.pendingCount), 32'h0);
        chk("clr3_stall", 32'(bus.stall), 32'h0);

        // Issue to r0 is a no-op.
        issue(5'd0);
        bus.rs = 5'd0; bus.rt = 5'd0;
        #1;
        chk("iss0_pend", 32'(bus.pendingCount), 32'h0);
        chk("iss0_stall", 32'(bus.stall), 32'h0);

        // Outstanding loads discarded by reset.
        issue(5'd1);
        issue(5'd2);
        issue(5'd3);
        issue(5'd4);
        chk("multi_pend4", 32'(bus.pendingCount), 32'h4);
        ld_ret(5'd1, 32'hA1);
        ld_ret(5'd4, 32'hA4);
        bus.rs = 5'd2; bus.rt = 5'd3;
        #1;
        chk("multi_pend2", 32'(bus.pendingCount), 32'h2);
        chk("multi_stall", 32'(bus.stall), 32'h1);
        reset = 1'b1;
        bus.issueValid = 1'b1; bus.issueRd = 5'd5;
        bus.regWrite = 1'b1; bus.rd = 5'd6; bus.writeData = 32'hCAFE;
        tick();
        reset = 1'b0;
        idle();
        #1;
        chk("mrst_pend", 32'(bus.pendingCount), 32'h0);
        chk("mrst_stall", 32'(bus.stall), 32'h0);
        bus.rs = 5'd5; bus.rt = 5'd6;
        #1;
        chk("mrst_stall5", 32'(bus.stall), 32'h0);
        chk("mrst_d5", bus.data1, 32'h0);
        chk("mrst_d6", bus.data2, 32'h0);
        ld_ret(5'd2, 32'hAB);
        bus.rs = 5'd2; bus.rt = 5'd1;
        #1;
        chk("postrst_ld_data", bus.data1, 32'hAB);
        chk("postrst_ld_d1", bus.data2, 32'h0);
        chk("postrst_ld_pend", 32'(bus.pendingCount), 32'h0);
        chk("postrst_ld_stall", 32'(bus.stall), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
